skew_feed_sequencer: RTL and testbench

Per-tile sequencer that drives the diagonal (skewed) operand feed of the output-stationary systolic array. On each tile start it pops the operand FIFOs in a staircase pattern, lane i delayed i cycles, holds the PE row/column valid masks, and counts out the drain (flush) window before signalling tile completion. The block sits between the tile-level control FSM, which issues TILE_START and the per-tile sizes, and the operand FIFO / PE array datapath.

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/skew_window_decode.sv | 36 +++
 rtl/skew_feed_sequencer.sv | 167 ++++++++++++++++
 tb/tb_skew_feed_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ============================================================================
// systolic_pkg - shared constants and state encoding for the systolic array
// Revision: 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int SA_ROWS      = 32;
    localparam int SA_ROWS_LOG2 = 5;
    localparam int SA_COLS      = 32;
    localparam int SA_COLS_LOG2 = 5;
    localparam int SA_K_LOG2    = 9;
    // One extra bit covers K + R + C - 2 without wrapping.
    localparam int SA_T_W       = SA_K_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/skew_window_decode.sv
// ============================================================================
// skew_window_decode - per-lane pop vector: lane i pops while i <= t < i+K
// Revision: 1.0
// ============================================================================
`default_nettype none

module skew_window_decode
    import systolic_pkg::*;
#(
    parameter int LANES      = SA_ROWS,
    parameter int LANES_LOG2 = SA_ROWS_LOG2,
    parameter int T_W        = SA_T_W,
    parameter int K_W        = SA_K_LOG2
) (
    input  logic                  en_i,
    input  logic [T_W-1:0]        t_i,
    input  logic [K_W-1:0]        k_i,
    input  logic [LANES_LOG2:0]   act_i,
    output logic [LANES-1:0]      pop_o
);

    logic [T_W-1:0] w_act;
    logic [T_W-1:0] w_k;

    assign w_act = T_W'(act_i);
    assign w_k   = T_W'(k_i);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [T_W-1:0] c_LANE = T_W'(i);
        assign pop_o[i] = en_i && (c_LANE < w_act) && (t_i >= c_LANE) &&
                          (t_i < c_LANE + w_k);
    end

endmodule

`default_nettype wire

// File: rtl/skew_feed_sequencer.sv
// ============================================================================
// skew_feed_sequencer - staircase operand feed, valid masks and drain window
// Optional: SKEW_SEQ_PERF_CNT_EN adds STALL_CYCLES_out stall counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module skew_feed_sequencer
    import systolic_pkg::*;
#(
    parameter int PE_ARRAY_NUM_ROWS      = SA_ROWS,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = SA_ROWS_LOG2,
    parameter int PE_ARRAY_NUM_COLS      = SA_COLS,
    parameter int PE_ARRAY_NUM_COLS_LOG2 = SA_COLS_LOG2,
    parameter int MAX_K_SIZE_LOG2        = SA_K_LOG2
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              TILE_START,
    input  logic                              STALL,
    input  logic [MAX_K_SIZE_LOG2-1:0]        K_SIZE,
    input  logic [PE_ARRAY_NUM_ROWS_LOG2:0]   ACTV_ROWS,
    input  logic [PE_ARRAY_NUM_COLS_LOG2:0]   ACTV_COLS,
    output logic [PE_ARRAY_NUM_ROWS-1:0]      OPND1_FIFO_POPEs_out,
    output logic [PE_ARRAY_NUM_COLS-1:0]      OPND2_FIFO_POPEs_out,
    output logic [PE_ARRAY_NUM_ROWS-1:0]      PE_ROW_VALID_out,
    output logic [PE_ARRAY_NUM_COLS-1:0]      PE_COL_VALID_out,
    output logic                              IS_COMPUTING_out,
    output logic                              IS_FLUSHING_out,
    output logic                              TILE_DONE_out
`ifdef SKEW_SEQ_PERF_CNT_EN
    ,output logic [15:0]                      STALL_CYCLES_out
`endif
);

    localparam int RW  = PE_ARRAY_NUM_ROWS_LOG2 + 1;
    localparam int CW  = PE_ARRAY_NUM_COLS_LOG2 + 1;
    localparam int T_W = MAX_K_SIZE_LOG2 + 1;

    seq_state_e                 state_q;
    logic [T_W-1:0]             t_q;
    logic [MAX_K_SIZE_LOG2-1:0] k_q;
    logic [RW-1:0]              r_q;
    logic [CW-1:0]              c_q;

    logic [RW-1:0]  w_r_clamp;
    logic [CW-1:0]  w_c_clamp;
    logic [T_W-1:0] w_r_t;
    logic [T_W-1:0] w_c_t;
    logic [T_W-1:0] w_feed_end;
    logic [T_W-1:0] w_flush_end;
    logic           w_active;
    logic           w_pop_en;

    assign w_r_clamp = (ACTV_ROWS > RW'(PE_ARRAY_NUM_ROWS)) ? RW'(PE_ARRAY_NUM_ROWS) : ACTV_ROWS;
    assign w_c_clamp = (ACTV_COLS > CW'(PE_ARRAY_NUM_COLS)) ? CW'(PE_ARRAY_NUM_COLS) : ACTV_COLS;

    assign w_r_t       = T_W'(r_q);
    assign w_c_t       = T_W'(c_q);
    // Both ends are >= 0 because a running tile has K, R, C all nonzero.
    assign w_feed_end  = T_W'(k_q) + ((w_r_t > w_c_t) ? w_r_t : w_c_t) - T_W'(2);
    assign w_flush_end = T_W'(k_q) + w_r_t + w_c_t - T_W'(2);

    assign w_active = (state_q == ST_FEED) || (state_q == ST_FLUSH);
    assign w_pop_en = w_active && !STALL;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (TILE_START) begin
                        k_q <= K_SIZE;
                        r_q <= w_r_clamp;
                        c_q <= w_c_clamp;
                        t_q <= '0;
                        if ((K_SIZE == '0) || (w_r_clamp == '0) || (w_c_clamp == '0))
                            state_q <= ST_DONE;
                        else
                            state_q <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (!STALL) begin
                        t_q <= t_q + T_W'(1);
                        if (t_q == w_feed_end)
                            state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!STALL) begin
                        if (t_q == w_flush_end) begin
                            t_q     <= '0;
                            state_q <= ST_DONE;
                        end else begin
                            t_q <= t_q + T_W'(1);
                        end
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    skew_window_decode #(
        .LANES      (PE_ARRAY_NUM_ROWS),
        .LANES_LOG2 (PE_ARRAY_NUM_ROWS_LOG2),
        .T_W        (T_W),
        .K_W        (MAX_K_SIZE_LOG2)
    ) u_row_decode (
        .en_i  (w_pop_en),
        .t_i   (t_q),
        .k_i   (k_q),
        .act_i (r_q),
        .pop_o (OPND1_FIFO_POPEs_out)
    );

    skew_window_decode #(
        .LANES      (PE_ARRAY_NUM_COLS),
        .LANES_LOG2 (PE_ARRAY_NUM_COLS_LOG2),
        .T_W        (T_W),
        .K_W        (MAX_K_SIZE_LOG2)
    ) u_col_decode (
        .en_i  (w_pop_en),
        .t_i   (t_q),
        .k_i   (k_q),
        .act_i (c_q),
        .pop_o (OPND2_FIFO_POPEs_out)
    );

    for (genvar i = 0; i < PE_ARRAY_NUM_ROWS; i++) begin : g_row_mask
        assign PE_ROW_VALID_out[i] = w_active && (RW'(i) < r_q);
    end

    for (genvar j = 0; j < PE_ARRAY_NUM_COLS; j++) begin : g_col_mask
        assign PE_COL_VALID_out[j] = w_active && (CW'(j) < c_q);
    end

    assign IS_COMPUTING_out = (state_q == ST_FEED);
    assign IS_FLUSHING_out  = (state_q == ST_FLUSH);
    assign TILE_DONE_out    = (state_q == ST_DONE);

`ifdef SKEW_SEQ_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && TILE_START) begin
            stall_cnt_q <= '0;
        end else if (w_active && STALL && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign STALL_CYCLES_out = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_skew_feed_sequencer.sv
// ============================================================================
// tb_skew_feed_sequencer - scoreboard bench for skew_feed_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_skew_feed_sequencer;

    logic        CLK;
    logic        RSTn;
    logic        TILE_START;
    logic        STALL;
    logic [8:0]  K_SIZE;
    logic [5:0]  ACTV_ROWS;
    logic [5:0]  ACTV_COLS;
    logic [31:0] OPND1_FIFO_POPEs_out;
    logic [31:0] OPND2_FIFO_POPEs_out;
    logic [31:0] PE_ROW_VALID_out;
    logic [31:0] PE_COL_VALID_out;
    logic        IS_COMPUTING_out;
    logic        IS_FLUSHING_out;
    logic        TILE_DONE_out;

    skew_feed_sequencer dut (
        .CLK                  (CLK),
        .RSTn                 (RSTn),
        .TILE_START           (TILE_START),
        .STALL                (STALL),
        .K_SIZE               (K_SIZE),
        .ACTV_ROWS            (ACTV_ROWS),
        .ACTV_COLS            (ACTV_COLS),
        .OPND1_FIFO_POPEs_out (OPND1_FIFO_POPEs_out),
        .OPND2_FIFO_POPEs_out (OPND2_FIFO_POPEs_out),
        .PE_ROW_VALID_out     (PE_ROW_VALID_out),
        .PE_COL_VALID_out     (PE_COL_VALID_out),
        .IS_COMPUTING_out     (IS_COMPUTING_out),
        .IS_FLUSHING_out      (IS_FLUSHING_out),
        .TILE_DONE_out        (TILE_DONE_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rp;
        logic [31:0] cp;
        logic [31:0] rv;
        logic [31:0] cv;
        logic        comp;
        logic        flush;
        logic        done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] therm(input int n);
        if (n >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << n) - 32'h1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rpop"},  OPND1_FIFO_POPEs_out, 32'h0);
        chk({tag, "_cpop"},  OPND2_FIFO_POPEs_out, 32'h0);
        chk({tag, "_rval"},  PE_ROW_VALID_out, 32'h0);
        chk({tag, "_cval"},  PE_COL_VALID_out, 32'h0);
        chk({tag, "_flags"}, {29'h0, IS_COMPUTING_out, IS_FLUSHING_out, TILE_DONE_out}, 32'h0);
    endtask

    // Cycle-level reference: one entry per cycle from cycle 1 to one idle cycle after DONE.
    task automatic gen_exp(input int k, input int ar, input int ac, input int st_lo, input int st_hi);
        int   rr, cc, mx, t, cyc;
        bit   stl;
        exp_t e;
        rr = (ar > 32) ? 32 : ar;
        cc = (ac > 32) ? 32 : ac;
        mx = (rr > cc) ? rr : cc;
        if (k == 0 || rr == 0 || cc == 0) begin
            e = '{default: 0};
            e.done = 1'b1;
            q.push_back(e);
        end else begin
            t   = 0;
            cyc = 1;
            for (int n = 0; n < 4000; n++) begin
                stl = (cyc >= st_lo) && (cyc <= st_hi);
                e = '{default: 0};
                e.rv = therm(rr);
                e.cv = therm(cc);
                if (t <= k + mx - 2) e.comp = 1'b1; else e.flush = 1'b1;
                for (int i = 0; i < 32; i++) begin
                    if (!stl && i < rr && t >= i && t < i + k) e.rp[i] = 1'b1;
                    if (!stl && i < cc && t >= i && t < i + k) e.cp[i] = 1'b1;
                end
                q.push_back(e);
                cyc++;
                if (!stl) begin
                    if (t == k + rr + cc - 2) break;
                    t++;
                end
            end
            e = '{default: 0};
            e.done = 1'b1;
            q.push_back(e);
        end
        e = '{default: 0};
        q.push_back(e);
    endtask

    task automatic run_tile(input int k, input int ar, input int ac,
                            input int st_lo, input int st_hi, input int re_cyc,
                            output int done_cyc, output int first31, output int last31);
        exp_t e;
        int   cyc;
        done_cyc = 0;
        first31  = 0;
        last31   = 0;
        gen_exp(k, ar, ac, st_lo, st_hi);
        K_SIZE     = 9'(k);
        ACTV_ROWS  = 6'(ar);
        ACTV_COLS  = 6'(ac);
        STALL      = 1'b0;
        TILE_START = 1'b1;
        @(posedge CLK);
        #1;
        // Sizes are don't-care once latched.
        K_SIZE    = 9'd1;
        ACTV_ROWS = 6'd1;
        ACTV_COLS = 6'd1;
        cyc = 1;
        while (q.size() > 0) begin
            STALL      = (cyc >= st_lo) && (cyc <= st_hi);
            TILE_START = (cyc == re_cyc);
            @(negedge CLK);
            e = q.pop_front();
            chk($sformatf("rpop_c%0d", cyc), OPND1_FIFO_POPEs_out, e.rp);
            chk($sformatf("cpop_c%0d", cyc), OPND2_FIFO_POPEs_out, e.cp);
            chk($sformatf("rval_c%0d", cyc), PE_ROW_VALID_out, e.rv);
            chk($sformatf("cval_c%0d", cyc), PE_COL_VALID_out, e.cv);
            chk($sformatf("flags_c%0d", cyc),
                {29'h0, IS_COMPUTING_out, IS_FLUSHING_out, TILE_DONE_out},
                {29'h0, e.comp, e.flush, e.done});
            if (TILE_DONE_out && done_cyc == 0) done_cyc = cyc;
            if (OPND1_FIFO_POPEs_out[31]) begin
                if (first31 == 0) first31 = cyc;
                last31 = cyc;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        TILE_START = 1'b0;
        STALL      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, f31, l31;
        RSTn       = 1'b0;
        TILE_START = 1'b0;
        STALL      = 1'b0;
        K_SIZE     = '0;
        ACTV_ROWS  = '0;
        ACTV_COLS  = '0;
        #12;
        chk_all_zero("reset");
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        run_tile(4, 2, 2, 0, -1, 0, dc, f31, l31);
        chk("done_cycle_k4r2c2", 32'(dc), 32'd8);

        run_tile(511, 32, 32, 0, -1, 0, dc, f31, l31);
        chk("done_cycle_k511", 32'(dc), 32'd575);
        chk("row31_first", 32'(f31), 32'd32);
        chk("row31_last", 32'(l31), 32'd542);

        run_tile(8, 4, 4, 3, 5, 0, dc, f31, l31);
        chk("done_cycle_stall", 32'(dc), 32'd19);

        run_tile(0, 4, 4, 0, -1, 0, dc, f31, l31);
        chk("done_cycle_k0", 32'(dc), 32'd1);

        run_tile(5, 0, 4, 0, -1, 0, dc, f31, l31);
        chk("done_cycle_r0", 32'(dc), 32'd1);

        // Clamped rows plus a TILE_START pulse mid-FEED that must be ignored.
        run_tile(5, 40, 3, 0, -1, 4, dc, f31, l31);
        chk("done_cycle_clamp", 32'(dc), 32'd40);

        // Asynchronous reset during FLUSH.
        K_SIZE     = 9'd4;
        ACTV_ROWS  = 6'd2;
        ACTV_COLS  = 6'd2;
        TILE_START = 1'b1;
        @(posedge CLK);
        #1;
        TILE_START = 1'b0;
        for (int i = 1; i < 6; i++) begin
            @(posedge CLK);
            #1;
        end
        chk("flush_before_reset", {31'h0, IS_FLUSHING_out}, 32'h1);
        #1;
        RSTn = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge CLK);
        #1;
        chk_all_zero("held_reset");
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        run_tile(4, 2, 2, 0, -1, 0, dc, f31, l31);
        chk("done_cycle_after_reset", 32'(dc), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
